// File: rtl/foc_sequencer.sv
// FOC sample sequencer: captures one sample and walks it through a chain of
// processing stages, with per-stage timeout, abort and a downstream flush.
module foc_sequencer #(
    parameter int                  D_WIDTH    = 16,
    parameter int                  N_STAGES   = 6,
    parameter logic [N_STAGES-1:0] FIXED_MASK = 6'b001000,
    parameter int                  TIMEOUT    = 255,
    parameter int                  CNT_WIDTH  = 16,
    localparam int                 IDX_W      = $clog2(N_STAGES)
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   valid,
    output logic                   ready,
    input  logic [5*D_WIDTH-1:0]   data_in,
    output logic [5*D_WIDTH-1:0]   data_r,
    output logic [N_STAGES-1:0]    stage_start,
    input  logic [N_STAGES-1:0]    stage_done,
    output logic                   mod_rstb,
    input  logic                   abort,
    input  logic                   clear_fault,
    output logic                   fault,
    output logic [IDX_W-1:0]       fault_stage,
    output logic [CNT_WIDTH-1:0]   last_latency,
    output logic [CNT_WIDTH-1:0]   run_count
);

    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_FLUSH,
        S_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [CNT_WIDTH-1:0]   lat_q, lat_d, lat_inc;
    logic [5*D_WIDTH-1:0]   data_r_q, data_r_d;
    logic [CNT_WIDTH-1:0]   last_latency_q, last_latency_d;
    logic [CNT_WIDTH-1:0]   run_count_q, run_count_d;
    logic                   fault_q, fault_d;
    logic [IDX_W-1:0]       fault_stage_q, fault_stage_d;
    logic                   ready_q, ready_d;
    logic [N_STAGES-1:0]    stage_start_q, stage_start_d;
    logic                   mod_rstb_q, mod_rstb_d;
    logic                   advance;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        idx_d          = idx_q;
        timer_d        = timer_q;
        lat_d          = lat_q;
        data_r_d       = data_r_q;
        last_latency_d = last_latency_q;
        run_count_d    = run_count_q;
        fault_d        = fault_q;
        fault_stage_d  = fault_stage_q;
        lat_inc        = (&lat_q) ? lat_q : lat_q + CNT_WIDTH'(1);
        advance        = FIXED_MASK[idx_q] | stage_done[idx_q];

        unique case (state_q)
            S_IDLE: begin
                if (valid) begin
                    data_r_d = data_in;
                    idx_d    = '0;
                    lat_d    = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (abort) begin
                    state_d = S_FLUSH;
                end else begin
                    timer_d = '0;
                    lat_d   = lat_inc;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Priority: abort, then done (fixed or returned), then timeout.
                if (abort) begin
                    state_d = S_FLUSH;
                end else if (advance) begin
                    lat_d = lat_inc;
                    if (idx_q == LAST_IDX) begin
                        last_latency_d = lat_inc;
                        run_count_d    = run_count_q + CNT_WIDTH'(1);
                        state_d        = S_FLUSH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_START;
                    end
                end else if (timer_q == TMR_MAX) begin
                    fault_d       = 1'b1;
                    fault_stage_d = idx_q;
                    state_d       = S_FAULT;
                end else begin
                    lat_d   = lat_inc;
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (clear_fault) begin
                    fault_d = 1'b0;
                    state_d = S_FLUSH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered yet
        // line up with the state they describe.
        ready_d       = (state_d == S_IDLE);
        mod_rstb_d    = !((state_d == S_FLUSH) || (state_d == S_FAULT));
        stage_start_d = (state_d == S_START) ? (N_STAGES'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            timer_q        <= '0;
            lat_q          <= '0;
            data_r_q       <= '0;
            last_latency_q <= '0;
            run_count_q    <= '0;
            fault_q        <= 1'b0;
            fault_stage_q  <= '0;
            ready_q        <= 1'b1;
            stage_start_q  <= '0;
            mod_rstb_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q        <= state_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            lat_q          <= lat_d;
            data_r_q       <= data_r_d;
            last_latency_q <= last_latency_d;
            run_count_q    <= run_count_d;
            fault_q        <= fault_d;
            fault_stage_q  <= fault_stage_d;
            ready_q        <= ready_d;
            stage_start_q  <= stage_start_d;
            mod_rstb_q     <= mod_rstb_d;
        end
    end

    assign ready        = ready_q;
    assign data_r       = data_r_q;
    assign stage_start  = stage_start_q;
    assign mod_rstb     = mod_rstb_q;
    assign fault        = fault_q;
    assign fault_stage  = fault_stage_q;
    assign last_latency = last_latency_q;
    assign run_count    = run_count_q;

endmodule

// File: tb/tb_foc_sequencer.sv
// Directed bench for foc_sequencer: a done responder answers each stage start
// after a per-stage delay, and each scenario task checks its own outcomes.
module tb_foc_sequencer;

    localparam int N  = 6;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int TO = 8;

    localparam logic [5*DW-1:0] D1 = {16'h1234, 16'h0a0b, 16'hc0de, 16'h5555, 16'h7f00};
    localparam logic [5*DW-1:0] D2 = {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    localparam logic [5*DW-1:0] D3 = {16'hffff, 16'h8000, 16'h7fff, 16'h0000, 16'h1111};
    localparam logic [5*DW-1:0] D4 = {16'hdead, 16'hbeef, 16'hcafe, 16'hf00d, 16'h0bad};
    localparam logic [5*DW-1:0] DX = {16'h9999, 16'h9999, 16'h9999, 16'h9999, 16'h9999};
    localparam logic [5*DW-1:0] D5 = {16'h2468, 16'h1357, 16'h0f0f, 16'hf0f0, 16'h3c3c};
    localparam logic [5*DW-1:0] D6 = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
    localparam logic [5*DW-1:0] D7 = {16'habcd, 16'h0123, 16'h4567, 16'h89ab, 16'hcdef};

    logic             clk = 1'b0;
    logic             rstb;
    logic             valid;
    logic             ready;
    logic [5*DW-1:0]  data_in;
    logic [5*DW-1:0]  data_r;
    logic [N-1:0]     stage_start;
    logic [N-1:0]     stage_done;
    logic [N-1:0]     resp_done;
    logic [N-1:0]     extra_done;
    logic             mod_rstb;
    logic             abort;
    logic             clear_fault;
    logic             fault;
    logic [2:0]       fault_stage;
    logic [CW-1:0]    last_latency;
    logic [CW-1:0]    run_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int launch_cyc = 0;
    int dly [N] = '{1, 1, 1, -1, 1, 1};
    int due [N] = '{default: -1};
    int log_stage [$];
    int log_cyc [$];
    int mod_low = 0;
    int onehot_err = 0;

    foc_sequencer #(
        .D_WIDTH   (DW),
        .N_STAGES  (N),
        .FIXED_MASK(6'b001000),
        .TIMEOUT   (TO),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .valid       (valid),
        .ready       (ready),
        .data_in     (data_in),
        .data_r      (data_r),
        .stage_start (stage_start),
        .stage_done  (stage_done),
        .mod_rstb    (mod_rstb),
        .abort       (abort),
        .clear_fault (clear_fault),
        .fault       (fault),
        .fault_stage (fault_stage),
        .last_latency(last_latency),
        .run_count   (run_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign stage_done = resp_done | extra_done;

    // Responder: a start seen in cycle k is answered in cycle k+1+dly (dly 0 = first WAIT cycle).
    always @(negedge clk) begin
        for (int s = 0; s < N; s++) begin
            if (!rstb) begin
                due[s]       <= -1;
                resp_done[s] <= 1'b0;
            end else begin
                if (stage_start[s] && dly[s] >= 0) due[s] <= cyc + 1 + dly[s];
                resp_done[s] <= (due[s] == cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rstb) begin
            if (stage_start != '0) begin
                if ($countones(stage_start) != 1) onehot_err <= onehot_err + 1;
                for (int s = 0; s < N; s++) begin
                    if (stage_start[s]) begin
                        log_stage.push_back(s);
                        log_cyc.push_back(cyc);
                    end
                end
            end
            if (!mod_rstb) mod_low <= mod_low + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic launch(input logic [5*DW-1:0] d);
        @(negedge clk);
        valid      = 1'b1;
        data_in    = d;
        launch_cyc = cyc;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_ready(input int max, output int at_cyc);
        at_cyc = -1;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, expected 1", ready, max);
        end
    endtask

    task automatic wait_start(input int s, input int max);
        bit seen = 1'b0;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (stage_start[s] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: stage_start[%0d] not seen in %0d cycles, expected pulse", s, max);
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0; valid = 1'b0; abort = 1'b0; clear_fault = 1'b0;
        data_in = '0; extra_done = '0;
        #12;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (stage_start !== '0) begin errors++; $display("FAIL reset_stage_start: got %b expected 0", stage_start); end
        checks++; if (mod_rstb !== 1'b1) begin errors++; $display("FAIL reset_mod_rstb: got %b expected 1", mod_rstb); end
        checks++; if (fault !== 1'b0 || fault_stage !== 3'd0) begin errors++; $display("FAIL reset_fault: got %b/%0d expected 0/0", fault, fault_stage); end
        checks++; if (data_r !== '0) begin errors++; $display("FAIL reset_data_r: got %h expected 0", data_r); end
        checks++; if (last_latency !== '0 || run_count !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", last_latency, run_count); end
        @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1 || stage_start !== '0) begin errors++; $display("FAIL reset_release: ready=%b start=%b expected 1/0", ready, stage_start); end
    endtask

    task automatic test_nominal();
        int base, mbase, r;
        dly = '{1, 1, 1, -1, 1, 1};
        base = log_stage.size(); mbase = mod_low;
        launch(D1);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL nom_ready_drop: got %b expected 0", ready); end
        wait_ready(80, r);
        checks++;
        if (log_stage.size() - base !== 6) begin
            errors++; $display("FAIL nom_pulses: got %0d expected 6", log_stage.size() - base);
        end else begin
            for (int i = 0; i < 6; i++)
                if (log_stage[base+i] != i) begin errors++; $display("FAIL nom_order: pulse %0d got stage %0d expected %0d", i, log_stage[base+i], i); end
            checks++; if (r - log_cyc[base] !== 18) begin errors++; $display("FAIL nom_ready_cycle: got %0d expected 18", r - log_cyc[base]); end
            checks++; if (log_cyc[base+4] - log_cyc[base+3] !== 2) begin errors++; $display("FAIL nom_fixed_gap: got %0d expected 2", log_cyc[base+4] - log_cyc[base+3]); end
        end
        checks++; if (last_latency !== 16'd17) begin errors++; $display("FAIL nom_latency: got %0d expected 17", last_latency); end
        checks++; if (run_count !== 16'd1) begin errors++; $display("FAIL nom_run_count: got %0d expected 1", run_count); end
        checks++; if (mod_low - mbase !== 1) begin errors++; $display("FAIL nom_mod_rstb: low %0d cycles expected 1", mod_low - mbase); end
        checks++; if (data_r !== D1) begin errors++; $display("FAIL nom_data_r: got %h expected %h", data_r, D1); end
    endtask

    task automatic test_timeout();
        int base, fc, r;
        dly = '{1, 1, -1, 1, 1, 1};
        base = log_stage.size(); fc = -1;
        launch(D2);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (fault === 1'b1) begin fc = cyc; break; end
        end
        checks++; if (fc < 0) begin errors++; $display("FAIL to_fault: got fault=%b expected 1", fault); end
        checks++; if (fault_stage !== 3'd2) begin errors++; $display("FAIL to_fault_stage: got %0d expected 2", fault_stage); end
        checks++; if (ready !== 1'b0 || mod_rstb !== 1'b0) begin errors++; $display("FAIL to_outputs: ready=%b mod_rstb=%b expected 0/0", ready, mod_rstb); end
        checks++;
        if (log_stage.size() - base !== 3) begin
            errors++; $display("FAIL to_pulses: got %0d expected 3", log_stage.size() - base);
        end else begin
            // One START cycle plus TIMEOUT+1 WAIT cycles before FAULT shows.
            checks++; if (fc - log_cyc[base+2] !== TO + 2) begin errors++; $display("FAIL to_fault_cycle: got %0d expected %0d", fc - log_cyc[base+2], TO + 2); end
        end
        repeat (3) @(negedge clk);
        checks++; if (fault !== 1'b1 || ready !== 1'b0 || log_stage.size() - base !== 3) begin errors++; $display("FAIL to_hold: fault=%b ready=%b pulses=%0d expected 1/0/3", fault, ready, log_stage.size() - base); end
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        checks++; if (fault !== 1'b0 || mod_rstb !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL to_flush: fault=%b mod_rstb=%b ready=%b expected 0/0/0", fault, mod_rstb, ready); end
        wait_ready(3, r);
        checks++; if (mod_rstb !== 1'b1) begin errors++; $display("FAIL to_mod_release: got %b expected 1", mod_rstb); end
        checks++; if (run_count !== 16'd1 || last_latency !== 16'd17) begin errors++; $display("FAIL to_counters: got %0d/%0d expected 1/17", run_count, last_latency); end
        checks++; if (fault_stage !== 3'd2) begin errors++; $display("FAIL to_fault_stage_hold: got %0d expected 2", fault_stage); end
    endtask

    task automatic test_done_at_timeout();
        int base, r;
        dly = '{1, 1, 1, -1, TO, 1};
        base = log_stage.size();
        launch(D3);
        wait_ready(80, r);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL dt_fault: got %b expected 0", fault); end
        checks++;
        if (log_stage.size() - base !== 6) begin
            errors++; $display("FAIL dt_pulses: got %0d expected 6", log_stage.size() - base);
        end else begin
            checks++; if (log_cyc[base+5] - log_cyc[base+4] !== TO + 2) begin errors++; $display("FAIL dt_gap: got %0d expected %0d", log_cyc[base+5] - log_cyc[base+4], TO + 2); end
        end
        checks++; if (last_latency !== 16'd24 || run_count !== 16'd2) begin errors++; $display("FAIL dt_counters: got %0d/%0d expected 24/2", last_latency, run_count); end
        checks++; if (fault_stage !== 3'd2) begin errors++; $display("FAIL dt_fault_stage: got %0d expected 2", fault_stage); end
    endtask

    task automatic test_abort();
        int base, mbase, r;
        dly = '{1, 1, 1, -1, 1, 1};
        base = log_stage.size(); mbase = mod_low;
        launch(D4);
        valid = 1'b1; data_in = DX;
        wait_start(3, 40);
        @(negedge clk);
        abort = 1'b1; valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (mod_rstb !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL ab_flush: mod_rstb=%b ready=%b expected 0/0", mod_rstb, ready); end
        wait_ready(3, r);
        repeat (3) @(negedge clk);
        checks++; if (log_stage.size() - base !== 4) begin errors++; $display("FAIL ab_pulses: got %0d expected 4", log_stage.size() - base); end
        checks++; if (run_count !== 16'd2 || last_latency !== 16'd24) begin errors++; $display("FAIL ab_counters: got %0d/%0d expected 2/24", run_count, last_latency); end
        checks++; if (data_r !== D4) begin errors++; $display("FAIL ab_data_r: got %h expected %h", data_r, D4); end
        checks++; if (mod_low - mbase !== 1) begin errors++; $display("FAIL ab_mod_rstb: low %0d cycles expected 1", mod_low - mbase); end
        base = log_stage.size();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1 || mod_rstb !== 1'b1 || log_stage.size() != base) begin errors++; $display("FAIL ab_idle: ready=%b mod_rstb=%b new_pulses=%0d expected 1/1/0", ready, mod_rstb, log_stage.size() - base); end
    endtask

    task automatic test_fixed_stray();
        int base, r;
        dly = '{1, 3, 1, -1, 1, 1};
        base = log_stage.size();
        extra_done = '1;
        repeat (2) @(negedge clk);
        extra_done = '0;
        checks++; if (ready !== 1'b1 || log_stage.size() != base) begin errors++; $display("FAIL fs_idle_done: ready=%b new_pulses=%0d expected 1/0", ready, log_stage.size() - base); end
        launch(D5);
        wait_start(1, 20);
        @(negedge clk);
        extra_done = 6'b100000;
        repeat (2) @(negedge clk);
        extra_done = '0;
        wait_ready(80, r);
        checks++;
        if (log_stage.size() - base !== 6) begin
            errors++; $display("FAIL fs_pulses: got %0d expected 6", log_stage.size() - base);
        end else begin
            checks++; if (log_cyc[base+2] - log_cyc[base+1] !== 5) begin errors++; $display("FAIL fs_stray_gap: got %0d expected 5", log_cyc[base+2] - log_cyc[base+1]); end
            checks++; if (log_cyc[base+4] - log_cyc[base+3] !== 2) begin errors++; $display("FAIL fs_fixed_gap: got %0d expected 2", log_cyc[base+4] - log_cyc[base+3]); end
        end
        checks++; if (last_latency !== 16'd19 || run_count !== 16'd3) begin errors++; $display("FAIL fs_counters: got %0d/%0d expected 19/3", last_latency, run_count); end
    endtask

    task automatic test_best_case();
        int r;
        dly = '{0, 0, 0, -1, 0, 0};
        launch(D2);
        wait_ready(40, r);
        // Counting the valid cycle and the ready cycle, 2*N+3 = 15 cycles.
        checks++; if (r - launch_cyc !== 2 * N + 2) begin errors++; $display("FAIL bc_ready_cycle: got %0d expected %0d", r - launch_cyc, 2 * N + 2); end
        checks++; if (last_latency !== 16'd12 || run_count !== 16'd4) begin errors++; $display("FAIL bc_counters: got %0d/%0d expected 12/4", last_latency, run_count); end
    endtask

    task automatic test_reset_midrun();
        int base, r;
        dly = '{1, 1, 1, -1, 1, 1};
        launch(D6);
        wait_start(2, 20);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || stage_start !== '0 || mod_rstb !== 1'b1) begin errors++; $display("FAIL rm_outputs: ready=%b start=%b mod_rstb=%b expected 1/0/1", ready, stage_start, mod_rstb); end
        checks++; if (fault !== 1'b0 || fault_stage !== 3'd0 || data_r !== '0) begin errors++; $display("FAIL rm_state: fault=%b stage=%0d data_r=%h expected 0/0/0", fault, fault_stage, data_r); end
        checks++; if (run_count !== '0 || last_latency !== '0) begin errors++; $display("FAIL rm_counters: got %0d/%0d expected 0/0", run_count, last_latency); end
        @(negedge clk);
        rstb = 1'b1;
        base = log_stage.size();
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1 || log_stage.size() != base) begin errors++; $display("FAIL rm_release: ready=%b new_pulses=%0d expected 1/0", ready, log_stage.size() - base); end
        launch(D7);
        wait_ready(80, r);
        checks++; if (log_stage.size() - base !== 6) begin errors++; $display("FAIL rm_pulses: got %0d expected 6", log_stage.size() - base); end
        checks++; if (run_count !== 16'd1 || last_latency !== 16'd17 || data_r !== D7) begin errors++; $display("FAIL rm_rerun: got %0d/%0d/%h expected 1/17/%h", run_count, last_latency, data_r, D7); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_done_at_timeout();
        test_abort();
        test_fixed_stray();
        test_best_case();
        test_reset_midrun();
        repeat (2) @(negedge clk);
        checks++; if (onehot_err !== 0) begin errors++; $display("FAIL onehot: %0d multi-hot start cycles expected 0", onehot_err); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
